// File: rtl/kalman_pkg.sv
// Shared types for the kalman_core blocks: Q2.14 scalars, 2x2 matrices and
// the inverse-engine arbiter state encoding.
package kalman_pkg;

  localparam int Q_W   = 16;
  localparam int MAT_W = 4 * Q_W;

  typedef logic signed [Q_W-1:0] q214_t;

  // Field a sits in the MSBs so the struct lines up with the {a,b,c,d} buses.
  typedef struct packed {
    q214_t a;
    q214_t b;
    q214_t c;
    q214_t d;
  } mat2_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN,
    ST_RECOV
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: picks the first requester at or after ptr,
// wrapping modulo N_REQ. Shared by the kalman_core resource arbiters.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  int              idx;
  logic [ID_W-1:0] sel;
  logic            found;

  assign any = |req;

  // NOTE: every variable gets a default before the loop so no path leaves one unassigned and infers a latch.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

// File: rtl/matinv_arbiter.sv
// Shares one 2x2 matrix-inverse engine between N_REQ Kalman channels:
// round-robin grant, start/complete sequencing, tagged responses, hang watchdog.
module matinv_arbiter
  import kalman_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ID_W        = 1,
  parameter int TIMEOUT_CYC = 255,
  parameter int RECOV_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*MAT_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ack,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [MAT_W-1:0]       resp_data,
  output logic                   resp_err,
  output logic                   resp_timeout,
  output logic                   busy,
  output logic                   inv_start,
  output logic [Q_W-1:0]         inv_a,
  output logic [Q_W-1:0]         inv_b,
  output logic [Q_W-1:0]         inv_c,
  output logic [Q_W-1:0]         inv_d,
  output logic                   inv_rst,
  input  logic [Q_W-1:0]         inv_a_inv,
  input  logic [Q_W-1:0]         inv_b_inv,
  input  logic [Q_W-1:0]         inv_c_inv,
  input  logic [Q_W-1:0]         inv_d_inv,
  input  logic                   inv_error,
  input  logic                   inv_ready
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RC_W = $clog2(RECOV_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECOV_CYC - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

  arb_state_t      state, state_n;
  logic [ID_W-1:0] rr_ptr, id_q, gnt_id;
  logic [N_REQ-1:0] gnt, ack_q;
  logic            any_req, grant, complete, wd_expired;
  logic            ready_q, err_q, tmo_q;
  logic [WD_W-1:0] wd_cnt;
  logic [RC_W-1:0] rc_cnt;
  mat2_t           op_q, res_q;
  mat2_t           req_mat [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_mat[i] = req_data[i*MAT_W +: MAT_W];
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  // A ready level still high from the previous job must never start a new one.
  assign grant      = (state == ST_IDLE) && any_req && !inv_ready;
  assign complete   = inv_ready && !ready_q;
  assign wd_expired = (wd_cnt == WD_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (grant) state_n = ST_ISSUE;
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (complete)        state_n = ST_RESP;
        else if (wd_expired) state_n = ST_RECOV;
      end
      ST_RESP:  state_n = tmo_q ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (!inv_ready) state_n = ST_IDLE;
      ST_RECOV: if (rc_cnt == RC_LAST) state_n = ST_RESP;
      default:  state_n = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
      ack_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      wd_cnt  <= '0;
      rc_cnt  <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state   <= state_n;
      ready_q <= inv_ready;
      ack_q   <= grant ? gnt : '0;
      unique case (state)
        ST_IDLE: if (grant) begin
          op_q   <= req_mat[gnt_id];
          id_q   <= gnt_id;
          wd_cnt <= '0;
          err_q  <= 1'b0;
          tmo_q  <= 1'b0;
        end
        ST_WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (complete) begin
            res_q <= {inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv};
            err_q <= inv_error;
          end else if (wd_expired) begin
            res_q  <= '0;
            err_q  <= 1'b1;
            tmo_q  <= 1'b1;
            rc_cnt <= '0;
          end
        end
        ST_RECOV: rc_cnt <= rc_cnt + 1'b1;
        ST_RESP:  rr_ptr <= (id_q == ID_LAST) ? '0 : id_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ack      = ack_q;
  assign busy         = (state != ST_IDLE);
  assign inv_start    = (state == ST_ISSUE);
  assign resp_valid   = (state == ST_RESP);
  assign resp_id      = id_q;
  assign resp_data    = res_q;
  assign resp_err     = resp_valid & err_q;
  assign resp_timeout = resp_valid & tmo_q;
  assign inv_a        = op_q.a;
  assign inv_b        = op_q.b;
  assign inv_c        = op_q.c;
  assign inv_d        = op_q.d;
  // Engine reset follows this block's reset as well as watchdog recovery.
  assign inv_rst      = ~reset_n | (state == ST_RECOV);

endmodule

// File: tb/tb_matinv_arbiter.sv
// Self-checking bench for matinv_arbiter: behavioural inverse engine, queue-based
// requesters and a round-robin reference model that predicts every response.
module tb_matinv_arbiter;
  import kalman_pkg::*;

  localparam int N_REQ = 2, ID_W = 1, TIMEOUT_CYC = 16, RECOV_CYC = 2;

  logic                   clk, reset_n;
  logic [N_REQ-1:0]       req_valid, req_ack;
  logic [N_REQ*64-1:0]    req_data;
  logic                   resp_valid, resp_err, resp_timeout, busy, inv_start, inv_rst;
  logic [ID_W-1:0]        resp_id;
  logic [63:0]            resp_data;
  logic [15:0]            inv_a, inv_b, inv_c, inv_d;
  logic [15:0]            inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv;
  logic                   inv_error, inv_ready;

  matinv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC), .RECOV_CYC(RECOV_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .resp_timeout(resp_timeout), .busy(busy), .inv_start(inv_start),
    .inv_a(inv_a), .inv_b(inv_b), .inv_c(inv_c), .inv_d(inv_d), .inv_rst(inv_rst),
    .inv_a_inv(inv_a_inv), .inv_b_inv(inv_b_inv), .inv_c_inv(inv_c_inv), .inv_d_inv(inv_d_inv),
    .inv_error(inv_error), .inv_ready(inv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] data;
    bit          err;
    bit          tmo;
  } rsp_t;

  int tests = 0, fails = 0;
  int start_cnt = 0, start_bad = 0, ack_cnt = 0, ack_bad = 0, resp_total = 0;
  int rst_run = 0, rst_last = 0;
  rsp_t resp_q[$], exp_q[$];
  logic [63:0] job_q [N_REQ][$];
  logic [63:0] mdl_q [N_REQ][$];
  int m_ptr = 0;

  bit eng_hang = 1'b0;
  int eng_hold = 0, eng_lat_min = 0, eng_lat_max = 3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact 2x2 inverse in Q2.14: inv = adj/det, each entry scaled by 2^28/det.
  function automatic logic [63:0] ref_inv(input logic [63:0] m, output bit err);
    longint a, b, c, d, det;
    a = longint'($signed(m[63:48]));
    b = longint'($signed(m[47:32]));
    c = longint'($signed(m[31:16]));
    d = longint'($signed(m[15:0]));
    det = a * d - b * c;
    if (det == 0) begin
      err = 1'b1;
      return '0;
    end
    err = 1'b0;
    return {16'((d <<< 28) / det), 16'(((-b) <<< 28) / det),
            16'(((-c) <<< 28) / det), 16'((a <<< 28) / det)};
  endfunction

  // Behavioural inverse engine, driven on the falling edge.
  initial begin
    int          e_state, e_cnt, e_hold;
    logic [63:0] e_res;
    bit          e_err;
    e_state = 0; e_cnt = 0; e_hold = 0; e_res = '0; e_err = 1'b0;
    inv_ready = 1'b0; inv_error = 1'b0;
    {inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv} = '0;
    forever begin
      @(negedge clk);
      if (inv_rst) begin
        e_state = 0; inv_ready = 1'b0; inv_error = 1'b0;
        {inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv} = '0;
      end else begin
        case (e_state)
          0: if (inv_start) e_state = 1;
          1: begin
            e_res   = ref_inv({inv_a, inv_b, inv_c, inv_d}, e_err);
            e_cnt   = int'($urandom_range(eng_lat_max, eng_lat_min));
            e_state = 2;
          end
          2: if (!eng_hang) begin
            if (e_cnt == 0) begin
              {inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv} = e_res;
              inv_error = e_err; inv_ready = 1'b1; e_hold = eng_hold; e_state = 3;
            end else e_cnt--;
          end
          default: if (e_hold == 0) begin
            inv_ready = 1'b0; e_state = 0;
          end else e_hold--;
        endcase
      end
    end
  end

  // Requesters: hold req_valid while jobs are queued, advance on req_ack.
  initial begin
    req_valid = '0; req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ack[i] && job_q[i].size() > 0) void'(job_q[i].pop_front());
        req_valid[i] = (job_q[i].size() > 0);
        if (job_q[i].size() > 0) req_data[i*64 +: 64] = job_q[i][0];
      end
    end
  end

  // Monitor, sampled just after the active edge.
  initial forever begin
    @(posedge clk); #1;
    if (resp_valid) begin
      resp_q.push_back('{id: int'(resp_id), data: resp_data, err: resp_err, tmo: resp_timeout});
      resp_total++;
    end
    if (inv_start) begin
      start_cnt++;
      if (inv_ready) start_bad++;
    end
    if (req_ack != '0) begin
      ack_cnt++;
      if (!$onehot(req_ack)) ack_bad++;
    end
    if (reset_n && inv_rst) rst_run++;
    else if (rst_run > 0) begin
      rst_last = rst_run; rst_run = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic submit(input int i, input logic [63:0] d);
    job_q[i].push_back(d);
    mdl_q[i].push_back(d);
  endtask

  // Reference order: jobs all pending at once are served circularly starting
  // at the pointer, which moves to one past each served requester.
  task automatic model_run();
    bit more;
    do begin
      more = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        int   idx;
        rsp_t e;
        idx = (m_ptr + k) % N_REQ;
        if (mdl_q[idx].size() > 0) begin
          e.id   = idx;
          e.data = ref_inv(mdl_q[idx].pop_front(), e.err);
          e.tmo  = 1'b0;
          exp_q.push_back(e);
          m_ptr = (idx + 1) % N_REQ;
          more  = 1'b1;
          break;
        end
      end
    end while (more);
  endtask

  task automatic expect_batch(input string tag, input int budget);
    int n, k;
    rsp_t e, r;
    n = exp_q.size(); k = 0;
    while (resp_q.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    check({tag, "_resp_arrived"}, resp_q.size() >= n, 1'b1);
    while (exp_q.size() > 0 && resp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = resp_q.pop_front();
      check({tag, "_id"},   r.id,   e.id);
      check({tag, "_data"}, r.data, e.data);
      check({tag, "_err"},  r.err,  e.err);
      check({tag, "_tmo"},  r.tmo,  e.tmo);
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      job_q[i].delete(); mdl_q[i].delete();
    end
    tick(2);
    reset_n = 1'b1;
    m_ptr = 0;
    resp_q.delete();
    tick(2);
  endtask

  initial begin
    int s0, a0, r0, k;
    rsp_t e;
    reset_n = 1'b0;
    tick(3);
    check("rst_ack",   req_ack, '0);
    check("rst_resp",  {resp_valid, resp_err, resp_timeout, resp_id}, '0);
    check("rst_data",  resp_data, '0);
    check("rst_busy",  busy, 1'b0);
    check("rst_start", inv_start, 1'b0);
    check("rst_ops",   {inv_a, inv_b, inv_c, inv_d}, '0);
    check("rst_inv_rst", inv_rst, 1'b1);
    reset_n = 1'b1;
    tick(1);
    check("rel_inv_rst", inv_rst, 1'b0);

    // Identity on requester 0.
    s0 = start_cnt; a0 = ack_cnt;
    submit(0, 64'h4000_0000_0000_4000);
    model_run();
    check("identity_model", exp_q[0].data, 64'h4000_0000_0000_4000);
    expect_batch("identity", 60);
    tick(4);
    check("identity_starts", start_cnt - s0, 1);
    check("identity_acks",   ack_cnt - a0, 1);

    // Singular matrix on requester 1; busy must clear once ready drops.
    eng_hold = 3;
    submit(1, 64'h4000_4000_4000_4000);
    model_run();
    expect_batch("singular", 60);
    k = 0;
    while (busy && k < 40) begin tick(1); k++; end
    check("singular_busy_low", busy, 1'b0);

    // Stale ready held high: no duplicate response, no early start.
    eng_hold = 5;
    r0 = resp_total; s0 = start_cnt;
    submit(0, {$urandom, $urandom});
    model_run();
    expect_batch("stale_a", 60);
    submit(1, {$urandom, $urandom});
    model_run();
    expect_batch("stale_b", 80);
    tick(12);
    check("stale_resp_count", resp_total - r0, 2);
    check("stale_starts", start_cnt - s0, 2);

    // Contention from reset: alternating 0,1,0,1.
    eng_hold = 0;
    do_reset();
    s0 = start_cnt;
    for (int j = 0; j < 2; j++) begin
      submit(0, {$urandom, $urandom});
      submit(1, {$urandom, $urandom});
    end
    model_run();
    check("cont_order", {exp_q[0].id[0], exp_q[1].id[0], exp_q[2].id[0], exp_q[3].id[0]}, 4'b0101);
    expect_batch("contention", 200);
    tick(4);
    check("cont_starts", start_cnt - s0, 4);

    // Randomised rounds.
    eng_lat_max = 6;
    for (int rnd = 0; rnd < 8; rnd++) begin
      eng_hold = int'($urandom_range(3, 0));
      for (int i = 0; i < N_REQ; i++)
        repeat ($urandom_range(2, 0))
          submit(i, ($urandom_range(3, 0) == 0) ? 64'h2000_1000_4000_2000 : {$urandom, $urandom});
      model_run();
      expect_batch("random", 300);
    end

    // Hung engine: watchdog, recovery pulse, forced timeout response.
    eng_hold = 0; eng_hang = 1'b1;
    submit(1, {$urandom, $urandom});
    model_run();
    e = exp_q.pop_back();
    e.data = '0; e.err = 1'b1; e.tmo = 1'b1;
    exp_q.push_back(e);
    expect_batch("hang", 120);
    check("hang_rst_cycles", rst_last, RECOV_CYC);
    eng_hang = 1'b0;
    tick(2);
    submit(0, {$urandom, $urandom});
    model_run();
    expect_batch("after_hang", 60);

    // Reset in the middle of a job: discarded, no response, engine reset.
    eng_lat_min = 10; eng_lat_max = 10;
    tick(4);
    s0 = start_cnt;
    submit(0, {$urandom, $urandom});
    mdl_q[0].delete();
    k = 0;
    while (start_cnt == s0 && k < 40) begin tick(1); k++; end
    check("midrst_started", start_cnt > s0, 1'b1);
    tick(3);
    r0 = resp_total;
    reset_n = 1'b0;
    tick(1);
    check("midrst_busy",    busy, 1'b0);
    check("midrst_inv_rst", inv_rst, 1'b1);
    check("midrst_outs",    {req_ack, resp_valid, resp_err, resp_timeout, inv_start}, '0);
    check("midrst_ops",     {inv_a, inv_b, inv_c, inv_d, resp_data}, '0);
    tick(1);
    reset_n = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < N_REQ; i++) job_q[i].delete();
    tick(15);
    check("midrst_no_resp", resp_total - r0, 0);
    eng_lat_min = 0; eng_lat_max = 3;
    submit(1, 64'h4000_0000_0000_4000);
    model_run();
    expect_batch("after_midrst", 60);

    tick(4);
    check("no_start_while_ready", start_bad, 0);
    check("ack_onehot", ack_bad, 0);
    check("no_extra_resp", resp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
